// File: rtl/branch_resolve.sv
// Control-flow resolver that works with the program-counter FSM. It latches branch and jump
// instructions, resolves them one cycle later, squashes the slot after a redirect and keeps statistics.
module branch_resolve #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      IP,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs1_val,
    input  logic [31:0]      rs2_val,
    output logic [6:0]       OP,
    output logic [31:0]      up_amt,
    output logic             b_taken,
    output logic             kill,
    output logic             illegal_br,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_NOP  = 7'b0010011;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      ip_q, ip_d;
    logic [31:0]      rs1_q, rs1_d;
    logic [31:0]      rs2_q, rs2_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic             fetch_is_ctrl;
    logic             load;
    logic [6:0]       opc_q;
    logic [2:0]       funct3_q;
    logic [31:0]      b_imm, j_imm, i_imm;
    logic [31:0]      jalr_target, jalr_off;
    logic             op_eq, op_lt_s, op_lt_u;
    logic             br_cond, br_illegal;
    logic             redirect;

    assign fetch_is_ctrl = (instr[6:0] == OPC_BR) || (instr[6:0] == OPC_JAL) ||
                           (instr[6:0] == OPC_JALR);
    assign load          = (state_q == ST_IDLE) && fetch_is_ctrl;

    assign opc_q    = instr_q[6:0];
    assign funct3_q = instr_q[14:12];

    assign b_imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                    instr_q[11:8], 1'b0};
    assign j_imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                    instr_q[30:21], 1'b0};
    assign i_imm = {{20{instr_q[31]}}, instr_q[31:20]};

    // The JALR offset is expressed relative to the latched IP, so the PC can add it like a branch offset.
    assign jalr_target = (rs1_q + i_imm) & ~32'd1;
    assign jalr_off    = jalr_target - ip_q;

    assign op_eq   = (rs1_q == rs2_q);
    assign op_lt_s = ($signed(rs1_q) < $signed(rs2_q));
    assign op_lt_u = (rs1_q < rs2_q);

    always_comb begin
        br_cond    = 1'b0;
        br_illegal = 1'b0;
        case (funct3_q)
            3'b000:  br_cond = op_eq;
            3'b001:  br_cond = ~op_eq;
            3'b100:  br_cond = op_lt_s;
            3'b101:  br_cond = ~op_lt_s;
            3'b110:  br_cond = op_lt_u;
            3'b111:  br_cond = ~op_lt_u;
            default: br_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        OP         = instr[6:0];
        b_taken    = 1'b0;
        up_amt     = 32'd0;
        kill       = 1'b0;
        illegal_br = 1'b0;
        redirect   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fetch_is_ctrl) begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                OP = opc_q;
                case (opc_q)
                    OPC_BR: begin
                        b_taken    = br_cond;
                        illegal_br = br_illegal;
                        up_amt     = b_imm;
                        redirect   = br_cond;
                    end
                    OPC_JAL: begin
                        up_amt   = j_imm;
                        redirect = 1'b1;
                    end
                    OPC_JALR: begin
                        up_amt   = jalr_off;
                        redirect = 1'b1;
                    end
                    default: ;
                endcase
                state_d = redirect ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                OP      = OPC_NOP;
                kill    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_d = load ? instr   : instr_q;
        ip_d    = load ? IP      : ip_q;
        rs1_d   = load ? rs1_val : rs1_q;
        rs2_d   = load ? rs2_val : rs2_q;
    end

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (state_q == ST_RESOLVE) begin
            if (!(&branch_cnt_q)) begin
                branch_cnt_d = branch_cnt_q + 1'b1;
            end
            if (redirect && !(&taken_cnt_q)) begin
                taken_cnt_d = taken_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            instr_q      <= 32'd0;
            ip_q         <= 32'd0;
            rs1_q        <= 32'd0;
            rs2_q        <= 32'd0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            ip_q         <= ip_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed test of branch_resolve. The driver queues the expected outputs for every cycle it drives,
// and a monitor compares the DUT outputs against them at each falling clock edge.
module tb_branch_resolve;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [31:0]   IP, instr, rs1_val, rs2_val;
    logic [6:0]    OP;
    logic [31:0]   up_amt;
    logic          b_taken, kill, illegal_br;
    logic [CW-1:0] branch_cnt, taken_cnt;

    branch_resolve #(.CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET), .IP(IP), .instr(instr),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .OP(OP), .up_amt(up_amt),
        .b_taken(b_taken), .kill(kill), .illegal_br(illegal_br),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [6:0]    op;
        logic          bt;
        logic [31:0]   up;
        logic          kl;
        logic          ill;
        logic          chk_cnt;
        logic [CW-1:0] bc;
        logic [CW-1:0] tc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    assertions = 0;
    int    failures   = 0;
    bit    drv_done   = 1'b0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] got,
                       input logic [31:0] want);
        assertions++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, got, want);
        end
    endtask

    // One clock cycle of stimulus together with the outputs expected in that cycle.
    task automatic step(input string nm, input logic rst, input logic [31:0] ip,
                        input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [6:0] eop, input logic ebt, input logic [31:0] eup,
                        input logic ekl, input logic eill, input logic ecc,
                        input logic [CW-1:0] ebc, input logic [CW-1:0] etc_v);
        exp_t e;
        @(posedge CLK);
        #1;
        RESET   = rst;
        IP      = ip;
        instr   = ins;
        rs1_val = r1;
        rs2_val = r2;
        e = '{op: eop, bt: ebt, up: eup, kl: ekl, ill: eill, chk_cnt: ecc, bc: ebc, tc: etc_v};
        exp_q.push_back(e);
        name_q.push_back(nm);
        $display("drive %s: RESET=%0b IP=%h instr=%h rs1=%h rs2=%h", nm, rst, ip, ins, r1, r2);
    endtask

    // Monitor: compares the current outputs against the oldest queued expectation.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, "OP",         {25'd0, OP},     {25'd0, e.op});
                chk(nm, "b_taken",    {31'd0, b_taken}, {31'd0, e.bt});
                chk(nm, "up_amt",     up_amt,          e.up);
                chk(nm, "kill",       {31'd0, kill},   {31'd0, e.kl});
                chk(nm, "illegal_br", {31'd0, illegal_br}, {31'd0, e.ill});
                if (e.chk_cnt) begin
                    chk(nm, "branch_cnt", {28'd0, branch_cnt}, {28'd0, e.bc});
                    chk(nm, "taken_cnt",  {28'd0, taken_cnt},  {28'd0, e.tc});
                end
                $display("check %s: OP=%h b_taken=%0b up_amt=%h kill=%0b illegal_br=%0b cnt=%0d/%0d",
                         nm, OP, b_taken, up_amt, kill, illegal_br, branch_cnt, taken_cnt);
            end else if (drv_done) begin
                $display("End of test - %0d assertions evaluated, %0d failures",
                         assertions, failures);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] beq16, bne8, jal_m8, jalr4, blt_m4, bltu_m4, bill_m4, bgeu_m4, beq8;
        beq16   = enc_b(3'b000, 13'd16);
        bne8    = enc_b(3'b001, 13'd8);
        jal_m8  = enc_j(21'h1F_FFF8);
        jalr4   = enc_jalr(12'd4);
        blt_m4  = enc_b(3'b100, 13'h1FFC);
        bltu_m4 = enc_b(3'b110, 13'h1FFC);
        bill_m4 = enc_b(3'b010, 13'h1FFC);
        bgeu_m4 = enc_b(3'b111, 13'h1FFC);
        beq8    = enc_b(3'b000, 13'd8);

        RESET = 1'b1; IP = 32'd0; instr = NOP; rs1_val = 32'd0; rs2_val = 32'd0;

        // Under reset the FSM stays idle while OP follows instr.
        step("rst_nop", 1, 32'h0, NOP,   0, 0, 7'h13, 0, 32'h0, 0, 0, 1, 0, 0);
        step("rst_br",  1, 32'h0, beq16, 0, 0, 7'h63, 0, 32'h0, 0, 0, 1, 0, 0);

        // BEQ with equal operands is taken, resolves after one cycle and flushes after that.
        step("beq_c0", 0, 32'h100, beq16, 5, 5, 7'h63, 0, 32'h0,  0, 0, 1, 0, 0);
        step("beq_c1", 0, 32'h104, NOP,   1, 2, 7'h63, 1, 32'h10, 0, 0, 1, 0, 0);
        step("beq_c2", 0, 32'h110, NOP,   0, 0, 7'h13, 0, 32'h0,  1, 0, 1, 1, 1);
        step("beq_c3", 0, 32'h114, NOP,   0, 0, 7'h13, 0, 32'h0,  0, 0, 1, 1, 1);

        // BNE with equal operands is not taken, so there is no flush cycle.
        step("bne_c0", 0, 32'h200, bne8, 7, 7, 7'h63, 0, 32'h0, 0, 0, 0, 0, 0);
        step("bne_c1", 0, 32'h204, NOP,  0, 9, 7'h63, 0, 32'h8, 0, 0, 0, 0, 0);
        step("bne_c2", 0, 32'h204, NOP,  0, 0, 7'h13, 0, 32'h0, 0, 0, 1, 2, 1);

        // JAL -8. A BEQ shown during the flush cycle must not be latched.
        step("jal_c0", 0, 32'h300, jal_m8, 0, 0, 7'h6F, 0, 32'h0,        0, 0, 0, 0, 0);
        step("jal_c1", 0, 32'h304, NOP,    0, 0, 7'h6F, 0, 32'hFFFF_FFF8, 0, 0, 0, 0, 0);
        step("jal_c2", 0, 32'h2F8, beq16,  0, 0, 7'h13, 0, 32'h0,        1, 0, 1, 3, 2);
        step("jal_c3", 0, 32'h2FC, NOP,    0, 0, 7'h13, 0, 32'h0,        0, 0, 1, 3, 2);

        // JALR: target (0x203+4)&~1 = 0x206, offset 0x106. A changed rs1 in the resolve cycle is ignored.
        step("jalr_c0", 0, 32'h100, jalr4, 32'h203,  0, 7'h67, 0, 32'h0,   0, 0, 0, 0, 0);
        step("jalr_c1", 0, 32'h104, NOP,   32'h1000, 0, 7'h67, 0, 32'h106, 0, 0, 0, 0, 0);
        step("jalr_c2", 0, 32'h206, NOP,   0,        0, 7'h13, 0, 32'h0,   1, 0, 1, 4, 3);
        step("jalr_c3", 0, 32'h20A, NOP,   0,        0, 7'h13, 0, 32'h0,   0, 0, 1, 4, 3);

        // Signed and unsigned compares of 0xFFFFFFFF against 1, plus an illegal funct3.
        step("blt_c0",  0, 32'h400, blt_m4,  32'hFFFF_FFFF, 1, 7'h63, 0, 32'h0,        0, 0, 0, 0, 0);
        step("blt_c1",  0, 32'h404, NOP,     0, 0,             7'h63, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        step("blt_c2",  0, 32'h3FC, NOP,     0, 0,             7'h13, 0, 32'h0,        1, 0, 1, 5, 4);
        step("blt_c3",  0, 32'h400, NOP,     0, 0,             7'h13, 0, 32'h0,        0, 0, 0, 0, 0);
        step("bltu_c0", 0, 32'h400, bltu_m4, 32'hFFFF_FFFF, 1, 7'h63, 0, 32'h0,        0, 0, 0, 0, 0);
        step("bltu_c1", 0, 32'h404, NOP,     0, 0,             7'h63, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        step("bltu_c2", 0, 32'h404, NOP,     0, 0,             7'h13, 0, 32'h0,        0, 0, 1, 6, 4);
        step("bill_c0", 0, 32'h400, bill_m4, 32'hFFFF_FFFF, 1, 7'h63, 0, 32'h0,        0, 0, 0, 0, 0);
        step("bill_c1", 0, 32'h404, NOP,     0, 0,             7'h63, 0, 32'hFFFF_FFFC, 0, 1, 0, 0, 0);
        step("bill_c2", 0, 32'h404, NOP,     0, 0,             7'h13, 0, 32'h0,        0, 0, 1, 7, 4);
        step("bgeu_c0", 0, 32'h400, bgeu_m4, 32'hFFFF_FFFF, 1, 7'h63, 0, 32'h0,        0, 0, 0, 0, 0);
        step("bgeu_c1", 0, 32'h404, NOP,     0, 0,             7'h63, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        step("bgeu_c2", 0, 32'h3FC, NOP,     0, 0,             7'h13, 0, 32'h0,        1, 0, 1, 8, 5);

        // Run 20 taken BEQs. The 4-bit counters must stop at 0xF (8+20 and 5+20 would otherwise wrap).
        for (int n = 0; n < 20; n++) begin
            step("sat_c0", 0, 32'h500, beq8, 3, 3, 7'h63, 0, 32'h0, 0, 0, 0, 0, 0);
            step("sat_c1", 0, 32'h504, NOP,  0, 0, 7'h63, 1, 32'h8, 0, 0, 0, 0, 0);
            step("sat_c2", 0, 32'h508, NOP,  0, 0, 7'h13, 0, 32'h0, 1, 0, 0, 0, 0);
        end
        step("sat_idle", 0, 32'h508, NOP, 0, 0, 7'h13, 0, 32'h0, 0, 0, 1, 4'hF, 4'hF);

        // Asserting reset in the middle of a resolve cycle gives an idle state and cleared counters at once.
        step("rr_c0",  0, 32'h600, beq8, 3, 3, 7'h63, 0, 32'h0, 0, 0, 1, 4'hF, 4'hF);
        step("rr_c1",  1, 32'h604, NOP,  0, 0, 7'h13, 0, 32'h0, 0, 0, 1, 0, 0);
        step("rr_c2",  1, 32'h604, NOP,  0, 0, 7'h13, 0, 32'h0, 0, 0, 1, 0, 0);
        step("rr_c3",  0, 32'h604, NOP,  0, 0, 7'h13, 0, 32'h0, 0, 0, 1, 0, 0);
        step("rr_c4",  0, 32'h608, NOP,  0, 0, 7'h13, 0, 32'h0, 0, 0, 1, 0, 0);

        @(posedge CLK);
        drv_done = 1'b1;
    end

endmodule
